slave_port: RTL and testbench

SLAVE_PORT -- requirements
Module: slave_port

---
 rtl/slave_port_if.sv | 35 +++
 rtl/slave_port.sv | 178 +++++++++++++++++
 tb/tb_slave_port.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_port_if.sv
// Bus-side and memory-side signal bundle for slave_port.
// The slave modport is the port's view; master is the bus/memory environment's view.
interface slave_port_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              S_SEL;
    logic              B_UTIL;
    logic              B_BUS_OUT;
    logic              B_SPL_RESUME;
    logic              S_DOUT;
    logic              S_DVALID;
    logic              S_SBSY;
    logic              S_DONE;
    logic              S_SPLIT;
    logic              S_RESUME_REQ;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_WDATA;
    logic              M_WEN;
    logic              M_REN;
    logic [DATA_W-1:0] M_RDATA;
    logic              M_RVALID;

    modport slave (
        input  S_SEL, B_UTIL, B_BUS_OUT, B_SPL_RESUME, M_RDATA, M_RVALID,
        output S_DOUT, S_DVALID, S_SBSY, S_DONE, S_SPLIT, S_RESUME_REQ,
        output M_ADDR, M_WDATA, M_WEN, M_REN
    );

    modport master (
        output S_SEL, B_UTIL, B_BUS_OUT, B_SPL_RESUME, M_RDATA, M_RVALID,
        input  S_DOUT, S_DVALID, S_SBSY, S_DONE, S_SPLIT, S_RESUME_REQ,
        input  M_ADDR, M_WDATA, M_WEN, M_REN
    );
endinterface

// File: rtl/slave_port.sv
// Serial-bus slave port: deserialises mode/address/data frames, drives a local memory, serialises read data.
// Define SLAVE_SPLIT_EN to compile in split-transaction support for slow memory reads.
module slave_port #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int SPLIT_WAIT = 4
) (
    input  logic CLK,
    input  logic RST,
    slave_port_if.slave bus
);
    localparam int CNT_W  = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
    localparam int WAIT_W = $clog2(SPLIT_WAIT + 1);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(SPLIT_WAIT);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEMWR, MEMRD, SPLIT, RDATA, DONE} state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef SLAVE_SPLIT_EN
    logic              resume_q, resume_d;
    logic              split_pulse;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef SLAVE_SPLIT_EN
        resume_d    = resume_q;
        split_pulse = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.S_SEL && bus.B_UTIL) begin
                    mode_d    = bus.B_BUS_OUT;
                    bit_cnt_d = '0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (!bus.B_UTIL) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    addr_d = {bus.B_BUS_OUT, addr_q[ADDR_W-1:1]};
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d  = '0;
                        wait_cnt_d = '0;
                        state_d    = mode_q ? WDATA : MEMRD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (!bus.B_UTIL) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    wdata_d = {bus.B_BUS_OUT, wdata_q[DATA_W-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = MEMWR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            MEMWR: state_d = DONE;
            MEMRD: begin
                // wait_cnt_q == 0 marks the strobe cycle; the counter saturates so the strobe never repeats
                if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_cnt_q != '0 && bus.M_RVALID) begin
                    rdata_d    = bus.M_RDATA;
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = RDATA;
                end
`ifdef SLAVE_SPLIT_EN
                else if (wait_cnt_q == WAIT_MAX) begin
                    split_pulse = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = SPLIT;
                end
`endif
            end
`ifdef SLAVE_SPLIT_EN
            SPLIT: begin
                if (!resume_q) begin
                    if (bus.M_RVALID) begin
                        rdata_d  = bus.M_RDATA;
                        resume_d = 1'b1;
                    end
                end else if (bus.B_SPL_RESUME) begin
                    resume_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = RDATA;
                end
            end
`endif
            RDATA: begin
                if (!bus.B_UTIL) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    rdata_d = rdata_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments; reset is synchronous and clears every flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef SLAVE_SPLIT_EN
            resume_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
`ifdef SLAVE_SPLIT_EN
            resume_q   <= resume_d;
`endif
        end
    end

    assign bus.S_SBSY   = (state_q != IDLE);
    assign bus.S_DVALID = (state_q == RDATA);
    assign bus.S_DOUT   = (state_q == RDATA) && rdata_q[0];
    assign bus.S_DONE   = (state_q == DONE);
    assign bus.M_WEN    = (state_q == MEMWR);
    assign bus.M_REN    = (state_q == MEMRD) && (wait_cnt_q == '0);
    assign bus.M_ADDR   = addr_q;
    assign bus.M_WDATA  = wdata_q;

`ifdef SLAVE_SPLIT_EN
    assign bus.S_SPLIT      = split_pulse;
    assign bus.S_RESUME_REQ = resume_q;
`else
    logic unused_split;
    assign unused_split     = bus.B_SPL_RESUME;
    assign bus.S_SPLIT      = 1'b0;
    assign bus.S_RESUME_REQ = 1'b0;
`endif
endmodule

// File: tb/tb_slave_port.sv
// Directed scoreboard bench for slave_port: write, read, abort, reset, and split or no-split read latency.
module tb_slave_port;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    slave_port_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    slave_port #(.ADDR_W(12), .DATA_W(8), .SPLIT_WAIT(4)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] rq[$];
    logic [7:0] rd_shift = '0;
    int         rd_bits = 0;
    int         wen_cnt = 0, ren_cnt = 0, done_cnt = 0, split_cnt = 0, resume_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: sampled at the falling edge, pops expected transactions as the DUT produces them.
    task automatic monitor();
        wr_t        w;
        logic [7:0] r;
        if (bus.S_DVALID !== 1'b1) check("dout_zero_when_invalid", bus.S_DOUT, 0);
        if (bus.M_REN === 1'b1) ren_cnt++;
        if (bus.S_SPLIT === 1'b1) split_cnt++;
        if (bus.S_RESUME_REQ === 1'b1) resume_cycles++;
        if (bus.M_WEN === 1'b1) begin
            wen_cnt++;
            check("wr_expected", wq.size() != 0, 1);
            if (wq.size() != 0) begin
                w = wq.pop_front();
                check("wr_addr", bus.M_ADDR, w.addr);
                check("wr_data", bus.M_WDATA, w.data);
            end
        end
        if (bus.S_DVALID === 1'b1) begin
            rd_shift = {bus.S_DOUT, rd_shift[7:1]};
            rd_bits++;
        end
        if (bus.S_DONE === 1'b1) begin
            done_cnt++;
            if (rd_bits != 0) begin
                check("rd_expected", rq.size() != 0, 1);
                check("rd_bit_count", rd_bits, 8);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    check("rd_data", rd_shift, r);
                end
                rd_bits = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic mode, input logic [11:0] addr, input logic [7:0] data);
        bus.S_SEL     = 1'b1;
        bus.B_UTIL    = 1'b1;
        bus.B_BUS_OUT = mode;
        cycle();
        bus.S_SEL = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.B_BUS_OUT = addr[i];
            cycle();
        end
        if (mode) begin
            for (int i = 0; i < 8; i++) begin
                bus.B_BUS_OUT = data[i];
                cycle();
            end
        end
        bus.B_BUS_OUT = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sbsy"},   bus.S_SBSY, 0);
        check({tag, "_dvalid"}, bus.S_DVALID, 0);
        check({tag, "_dout"},   bus.S_DOUT, 0);
        check({tag, "_done"},   bus.S_DONE, 0);
        check({tag, "_split"},  bus.S_SPLIT, 0);
        check({tag, "_resume"}, bus.S_RESUME_REQ, 0);
        check({tag, "_maddr"},  bus.M_ADDR, 0);
        check({tag, "_mwdata"}, bus.M_WDATA, 0);
        check({tag, "_wen"},    bus.M_WEN, 0);
        check({tag, "_ren"},    bus.M_REN, 0);
    endtask

    task automatic serialize_and_finish(input string tag);
        check({tag, "_dvalid_first"}, bus.S_DVALID, 1);
        for (int i = 0; i < 8; i++) cycle();
        check({tag, "_done_pulse"}, bus.S_DONE, 1);
        cycle();
        check({tag, "_done_one"}, bus.S_DONE, 0);
        check({tag, "_idle_sbsy"}, bus.S_SBSY, 0);
        bus.B_UTIL = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected run to finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wen0, ren0, done0;
        logic busy_dropped;
        rst              = 1'b1;
        bus.S_SEL        = 1'b0;
        bus.B_UTIL       = 1'b0;
        bus.B_BUS_OUT    = 1'b0;
        bus.B_SPL_RESUME = 1'b0;
        bus.M_RDATA      = '0;
        bus.M_RVALID     = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        check_all_zero("reset");

        // write 0x3C to 0x0A5: strobe after 21 frame cycles, done one cycle later
        wq.push_back('{addr: 12'h0A5, data: 8'h3C});
        send_frame(1'b1, 12'h0A5, 8'h3C);
        check("wr_wen_on_time", bus.M_WEN, 1);
        check("wr_sbsy", bus.S_SBSY, 1);
        cycle();
        check("wr_wen_one_cycle", bus.M_WEN, 0);
        check("wr_done_pulse", bus.S_DONE, 1);
        cycle();
        check("wr_done_one", bus.S_DONE, 0);
        check("wr_idle_sbsy", bus.S_SBSY, 0);
        check("wr_wen_count", wen_cnt, 1);
        bus.B_UTIL = 1'b0;
        cycle();

        // read 0x7FF, memory answers two cycles after the strobe with 0xA5
        rq.push_back(8'hA5);
        send_frame(1'b0, 12'h7FF, 8'h00);
        check("rd_ren_first", bus.M_REN, 1);
        check("rd_maddr", bus.M_ADDR, 12'h7FF);
        cycle();
        check("rd_ren_one_cycle", bus.M_REN, 0);
        cycle();
        bus.M_RVALID = 1'b1;
        bus.M_RDATA  = 8'hA5;
        cycle();
        bus.M_RVALID = 1'b0;
        bus.M_RDATA  = 8'h00;
        serialize_and_finish("rd");
        check("rd_wdata_held", bus.M_WDATA, 8'h3C);
        check("rd_ren_count", ren_cnt, 1);
        cycle();

        // abort: bus released after five address bits
        wen0  = wen_cnt;
        ren0  = ren_cnt;
        done0 = done_cnt;
        bus.S_SEL     = 1'b1;
        bus.B_UTIL    = 1'b1;
        bus.B_BUS_OUT = 1'b1;
        cycle();
        bus.S_SEL = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.B_BUS_OUT = i[0];
            cycle();
        end
        check("abort_sbsy_before", bus.S_SBSY, 1);
        bus.B_UTIL = 1'b0;
        cycle();
        check("abort_sbsy_low", bus.S_SBSY, 0);
        repeat (3) cycle();
        check("abort_no_wen", wen_cnt, wen0);
        check("abort_no_ren", ren_cnt, ren0);
        check("abort_no_done", done_cnt, done0);
        check("abort_wdata_held", bus.M_WDATA, 8'h3C);

`ifdef SLAVE_SPLIT_EN
        // slow memory: split after four waits, data at ten, resume on arbiter ack
        rq.push_back(8'hA5);
        send_frame(1'b0, 12'h123, 8'h00);
        check("sp_ren_first", bus.M_REN, 1);
        repeat (4) cycle();
        #1;
        check("sp_split_pulse", bus.S_SPLIT, 1);
        cycle();
        check("sp_split_one", bus.S_SPLIT, 0);
        check("sp_sbsy", bus.S_SBSY, 1);
        check("sp_resume_before_data", bus.S_RESUME_REQ, 0);
        bus.B_UTIL = 1'b0;
        bus.S_SEL  = 1'b1;
        repeat (5) cycle();
        bus.M_RVALID = 1'b1;
        bus.M_RDATA  = 8'hA5;
        cycle();
        bus.M_RVALID = 1'b0;
        bus.M_RDATA  = 8'h00;
        check("sp_resume_raised", bus.S_RESUME_REQ, 1);
        repeat (2) cycle();
        check("sp_resume_held", bus.S_RESUME_REQ, 1);
        check("sp_no_data_yet", bus.S_DVALID, 0);
        bus.B_SPL_RESUME = 1'b1;
        bus.B_UTIL       = 1'b1;
        bus.S_SEL        = 1'b0;
        cycle();
        bus.B_SPL_RESUME = 1'b0;
        check("sp_resume_dropped", bus.S_RESUME_REQ, 0);
        serialize_and_finish("sp");
        check("sp_split_count", split_cnt, 1);
        cycle();

        // data arriving on the timeout cycle wins over the split
        rq.push_back(8'h96);
        send_frame(1'b0, 12'h0F0, 8'h00);
        repeat (4) cycle();
        bus.M_RVALID = 1'b1;
        bus.M_RDATA  = 8'h96;
        #1;
        check("prio_no_split", bus.S_SPLIT, 0);
        cycle();
        bus.M_RVALID = 1'b0;
        bus.M_RDATA  = 8'h00;
        serialize_and_finish("prio");
        check("prio_split_count", split_cnt, 1);
        cycle();

        // reset while parked in SPLIT
        send_frame(1'b0, 12'h321, 8'h00);
        repeat (5) cycle();
        check("rst_in_split_busy", bus.S_SBSY, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_all_zero("rst_split");
`else
        // no split support: memory answers twenty cycles late, port simply stays busy
        rq.push_back(8'h5A);
        send_frame(1'b0, 12'h456, 8'h00);
        check("ns_ren_first", bus.M_REN, 1);
        busy_dropped = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (bus.S_SBSY !== 1'b1 || bus.S_DVALID !== 1'b0) busy_dropped = 1'b1;
        end
        bus.M_RVALID = 1'b1;
        bus.M_RDATA  = 8'h5A;
        cycle();
        bus.M_RVALID = 1'b0;
        bus.M_RDATA  = 8'h00;
        check("ns_busy_held", busy_dropped, 0);
        check("ns_no_split", split_cnt, 0);
        check("ns_no_resume", resume_cycles, 0);
        check("ns_ren_count", ren_cnt, 2);
        serialize_and_finish("ns");
        cycle();

        // reset while waiting on memory
        send_frame(1'b0, 12'h321, 8'h00);
        repeat (3) cycle();
        check("rst_in_wait_busy", bus.S_SBSY, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_all_zero("rst_wait");
`endif
        done0 = done_cnt;
        bus.M_RVALID = 1'b1;
        bus.M_RDATA  = 8'hFF;
        cycle();
        bus.M_RVALID = 1'b0;
        bus.M_RDATA  = 8'h00;
        check("post_rst_rvalid_ignored_resume", bus.S_RESUME_REQ, 0);
        check("post_rst_rvalid_ignored_sbsy", bus.S_SBSY, 0);
        repeat (2) cycle();
        check("post_rst_no_dvalid", bus.S_DVALID, 0);
        check("post_rst_no_done", done_cnt, done0);
        check("wr_queue_drained", wq.size(), 0);
        check("rd_queue_drained", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
